// File: rtl/fpu_exp_adder_arbiter.sv
// Biased 8-bit exponent adder (sum = exp1+exp2-128 with ovf/unf) shared between two FPU requesters.
// Latency: 1 cycle from request transfer to out_valid. Round-robin arbitration under contention.
// Backpressure: a held result with out_ready low stalls both requesters. flush drops the held result.

// Single shared biased exponent adder. All arithmetic for the block lives here.
module adder_8b (
  input  logic [7:0] i_exp1,
  input  logic [7:0] i_exp2,
  output logic [7:0] o_sum,
  output logic       o_ovf,
  output logic       o_unf
);

  logic [8:0] w_s;

  // 9-bit raw sum. The bias is removed modulo 256, and range flags come from the raw sum.
  always_comb begin
    w_s   = {1'b0, i_exp1} + {1'b0, i_exp2};
    o_sum = w_s[7:0] - 8'h80;
    o_unf = (w_s < 9'd128);
    o_ovf = (w_s > 9'd383);
  end

endmodule

module fpu_exp_adder_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_exp1,
  input  logic [7:0]       req0_exp2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_exp1,
  input  logic [7:0]       req1_exp2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag
);

  logic             r_out_valid;
  logic [7:0]       r_out_sum;
  logic             r_out_ovf;
  logic             r_out_unf;
  logic             r_out_src;
  logic [TAG_W-1:0] r_out_tag;
  // Requester granted most recently. Reset to 1 so requester 0 wins the first contention.
  logic             r_last_grant;

  logic             w_accept;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_xfer0;
  logic             w_xfer1;
  logic [7:0]       w_exp1;
  logic [7:0]       w_exp2;
  logic [TAG_W-1:0] w_tag;
  logic [7:0]       w_sum;
  logic             w_ovf;
  logic             w_unf;

  // Arbitration and handshake. The result slot frees up when it is empty or being drained this cycle.
  always_comb begin
    w_accept   = ~flush & (~r_out_valid | out_ready);
    w_grant0   = req0_valid & (~req1_valid | r_last_grant);
    w_grant1   = req1_valid & (~req0_valid | ~r_last_grant);
    req0_ready = w_accept & w_grant0;
    req1_ready = w_accept & w_grant1;
    w_xfer0    = req0_valid & req0_ready;
    w_xfer1    = req1_valid & req1_ready;
  end

  // Operand mux into the single shared adder, steered by the grant.
  always_comb begin
    w_exp1 = w_grant1 ? req1_exp1 : req0_exp1;
    w_exp2 = w_grant1 ? req1_exp2 : req0_exp2;
    w_tag  = w_grant1 ? req1_tag  : req0_tag;
  end

  adder_8b u_adder (
    .i_exp1 (w_exp1),
    .i_exp2 (w_exp2),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf)
  );

  // Result register. It loads on a transfer and clears valid on a drain or flush. Payload is kept when idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_valid  <= 1'b0;
      r_out_sum    <= 8'h00;
      r_out_ovf    <= 1'b0;
      r_out_unf    <= 1'b0;
      r_out_src    <= 1'b0;
      r_out_tag    <= '0;
      r_last_grant <= 1'b1;
    end else if (w_xfer0 | w_xfer1) begin
      r_out_valid  <= 1'b1;
      r_out_sum    <= w_sum;
      r_out_ovf    <= w_ovf;
      r_out_unf    <= w_unf;
      r_out_src    <= w_xfer1;
      r_out_tag    <= w_tag;
      r_last_grant <= w_xfer1;
    end else if (flush | out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_unf   = r_out_unf;
  assign out_src   = r_out_src;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_fpu_exp_adder_arbiter.sv
module tb_fpu_exp_adder_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       flush;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_exp1, req0_exp2;
  logic [3:0] req0_tag;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_exp1, req1_exp2;
  logic [3:0] req1_tag;
  logic       out_valid, out_ready;
  logic [7:0] out_sum;
  logic       out_ovf, out_unf, out_src;
  logic [3:0] out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fpu_exp_adder_arbiter #(.TAG_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_exp1  (req0_exp1),
    .req0_exp2  (req0_exp2),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_exp1  (req1_exp1),
    .req1_exp2  (req1_exp2),
    .req1_tag   (req1_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .out_src    (out_src),
    .out_tag    (out_tag)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       ovf;
    logic       unf;
    logic       src;
    logic [3:0] tag;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       ovf;
    logic       unf;
  } vec_t;

  res_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic, written from the formula.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic s, input logic [3:0] t);
    res_t r;
    int   x;
    x     = int'(a) + int'(b);
    r.sum = 8'(x - 128);
    r.ovf = (x > 383);
    r.unf = (x < 128);
    r.src = s;
    r.tag = t;
    return r;
  endfunction

  // Scoreboard: pop on drain (discard on flush), push on each request transfer.
  always @(negedge CLK) begin
    res_t e;
    if (RST) begin
      sb_q.delete();
    end else begin
      if (out_valid && (flush || out_ready)) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (!flush)
            chk("sb_result", 32'({out_sum, out_ovf, out_unf, out_src, out_tag}), 32'(e));
        end
      end
      if (req0_valid && req0_ready) sb_q.push_back(model(req0_exp1, req0_exp2, 1'b0, req0_tag));
      if (req1_valid && req1_ready) sb_q.push_back(model(req1_exp1, req1_exp2, 1'b1, req1_tag));
    end
  end

  // Present one request and wait (bounded) for its transfer. Returns at the posedge+1 after the transfer.
  task automatic send(input logic n, input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    int k;
    if (!n) begin
      req0_exp1 = a; req0_exp2 = b; req0_tag = t; req0_valid = 1'b1;
    end else begin
      req1_exp1 = a; req1_exp2 = b; req1_tag = t; req1_valid = 1'b1;
    end
    k = 0;
    @(negedge CLK);
    while (!(n ? req1_ready : req0_ready) && k < 50) begin
      k++;
      @(negedge CLK);
    end
    chk("send_ready", 32'(n ? req1_ready : req0_ready), 32'd1);
    @(posedge CLK); #1;
    if (!n) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{a: 8'h10, b: 8'h20, sum: 8'hB0, ovf: 1'b0, unf: 1'b1};
    tbl[1] = '{a: 8'h00, b: 8'h80, sum: 8'h00, ovf: 1'b0, unf: 1'b0};
    tbl[2] = '{a: 8'hFF, b: 8'h80, sum: 8'hFF, ovf: 1'b0, unf: 1'b0};
    tbl[3] = '{a: 8'hC0, b: 8'hC0, sum: 8'h00, ovf: 1'b1, unf: 1'b0};
    tbl[4] = '{a: 8'hFF, b: 8'hFF, sum: 8'h7E, ovf: 1'b1, unf: 1'b0};

    RST = 1'b0; flush = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b0; req0_exp1 = '0; req0_exp2 = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_exp1 = '0; req1_exp2 = '0; req1_tag = '0;
    #1 RST = 1'b1;
    #2;
    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_flags", 32'({out_ovf, out_unf}), 32'd0);
    chk("rst_src",   32'(out_src),   32'd0);
    chk("rst_tag",   32'(out_tag),   32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Contention right after reset: strict alternation starting with requester 0
    req0_exp1 = 8'h90; req0_exp2 = 8'h11; req0_tag = 4'h1; req0_valid = 1'b1;
    req1_exp1 = 8'h70; req1_exp2 = 8'h22; req1_tag = 4'h2; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (i == 5) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge CLK);
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_src",   32'(out_src),   32'(i % 2));
    end
    @(posedge CLK); #1;

    // Single request, one-cycle latency
    send(1'b0, 8'h80, 8'h05, 4'hA);
    @(negedge CLK);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sum",   32'(out_sum),   32'h05);
    chk("t1_flags", 32'({out_ovf, out_unf}), 32'd0);
    chk("t1_src",   32'(out_src),   32'd0);
    chk("t1_tag",   32'(out_tag),   32'hA);
    @(posedge CLK); #1;

    // Flag boundary table
    for (int i = 0; i < 5; i++) begin
      send(1'b0, tbl[i].a, tbl[i].b, 4'(i));
      @(negedge CLK);
      chk("tbl_sum", 32'(out_sum), 32'(tbl[i].sum));
      chk("tbl_ovf", 32'(out_ovf), 32'(tbl[i].ovf));
      chk("tbl_unf", 32'(out_unf), 32'(tbl[i].unf));
      chk("tbl_tag", 32'(out_tag), 32'(i));
    end
    @(posedge CLK); #1;

    // Backpressure stall with contention, then drain plus accept in one cycle
    out_ready = 1'b0;
    send(1'b0, 8'h90, 8'h10, 4'h3);
    req0_exp1 = 8'h81; req0_exp2 = 8'h01; req0_tag = 4'h5; req0_valid = 1'b1;
    req1_exp1 = 8'h82; req1_exp2 = 8'h02; req1_tag = 4'h6; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_rdy",   32'({req0_ready, req1_ready}), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hold",  32'({out_sum, out_src, out_tag}), 32'({8'h20, 1'b0, 4'h3}));
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    @(negedge CLK);
    chk("bp_grant", 32'({req0_ready, req1_ready}), 32'b01);
    @(posedge CLK); #1 req1_valid = 1'b0;
    @(negedge CLK);
    chk("bp_b2b1", 32'({out_valid, out_src, out_tag, out_sum}), 32'({1'b1, 1'b1, 4'h6, 8'h04}));
    chk("bp_rdy0", 32'(req0_ready), 32'd1);
    @(posedge CLK); #1 req0_valid = 1'b0;
    @(negedge CLK);
    chk("bp_b2b2", 32'({out_valid, out_src, out_tag, out_sum}), 32'({1'b1, 1'b0, 4'h5, 8'h02}));
    @(posedge CLK); #1;

    // Flush drops held result and blocks acceptance for that cycle
    out_ready = 1'b0;
    send(1'b0, 8'h85, 8'h05, 4'h8);
    req1_exp1 = 8'hA0; req1_exp2 = 8'h01; req1_tag = 4'h9; req1_valid = 1'b1;
    flush = 1'b1;
    @(negedge CLK);
    chk("fl_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge CLK); #1 flush = 1'b0;
    @(negedge CLK);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_rdy1",  32'(req1_ready), 32'd1);
    @(posedge CLK); #1 req1_valid = 1'b0;
    @(negedge CLK);
    chk("fl_res", 32'({out_valid, out_src, out_tag, out_sum}), 32'({1'b1, 1'b1, 4'h9, 8'h21}));
    @(posedge CLK); #1 out_ready = 1'b1;
    @(posedge CLK); #1;

    // Reset mid-stream, then the first contention goes to requester 0
    req0_exp1 = 8'h80; req0_exp2 = 8'h01; req0_tag = 4'h7; req0_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_tag",   32'(out_tag),   32'd0);
    req0_valid = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b0;
    req0_valid = 1'b1;
    req1_exp1 = 8'h80; req1_exp2 = 8'h02; req1_tag = 4'hB; req1_valid = 1'b1;
    @(negedge CLK);
    chk("mr_grant", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge CLK); #1 begin req0_valid = 1'b0; req1_valid = 1'b0; end
    @(negedge CLK);
    chk("mr_src", 32'({out_valid, out_src}), 32'b10);
    @(posedge CLK); #1;

    // Exhaustive sweep through requester 1, checked by the scoreboard
    for (int i = 0; i < 65536; i++) begin
      send(1'b1, 8'(i >> 8), 8'(i), 4'(i));
    end
    repeat (2) @(negedge CLK);
    chk("sb_empty",   32'(sb_q.size()), 32'd0);
    chk("end_valid",  32'(out_valid),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
